// File: rtl/qos_pkg.sv
// Shared types and constants for the QoS channel selector: FSM state encoding,
// channel count, timer width and the reset_timer==0 substitute value.
package qos_pkg;

  localparam int NUM_CH  = 4;
  localparam int TIMER_W = 20;

  // A programmed reset_timer of zero selects the longest representable interval.
  localparam logic [TIMER_W-1:0] RT_ZERO_SUB = 20'hF_FFFF;

  typedef enum logic [1:0] {
    ST_LOCK = 2'd0,
    ST_PEND = 2'd1,
    ST_HOLD = 2'd2
  } sel_state_e;

  typedef struct packed {
    logic               fallback_enable;
    logic               manual_enable;
    logic [1:0]         manual_channel;
    logic [7:0]         channel_priority;
    logic [TIMER_W-1:0] reset_timer;
  } qos_cfg_t;

  function automatic logic [TIMER_W-1:0] eff_limit(input logic [TIMER_W-1:0] rt);
    return (rt == '0) ? RT_ZERO_SUB : rt;
  endfunction

endpackage

// File: rtl/qos_channel_selector_if.sv
// Transport-stream bus between the four input channels and the selected output.
// The selector uses the slave modport; the stream source/sink uses master.
interface qos_channel_selector_if;
  import qos_pkg::*;

  logic [NUM_CH-1:0]   ts_valid;
  logic [NUM_CH-1:0]   ts_start;
  logic [NUM_CH-1:0]   ts_err;
  logic [8*NUM_CH-1:0] ts_data;

  logic                out_valid;
  logic                out_start;
  logic [7:0]          out_data;

  modport master (
    output ts_valid, ts_start, ts_err, ts_data,
    input  out_valid, out_start, out_data
  );

  modport slave (
    input  ts_valid, ts_start, ts_err, ts_data,
    output out_valid, out_start, out_data
  );
endinterface

// File: rtl/qos_chan_monitor.sv
// Per-channel health monitor: presence timer re-armed by packet starts and a
// saturating error counter cleared by the shared window.
module qos_chan_monitor
  import qos_pkg::*;
#(
  parameter int ERR_THRESH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ts_valid,
  input  logic               ts_start,
  input  logic               ts_err,
  input  logic               win_clear,
  input  logic [TIMER_W-1:0] limit,
  output logic               present,
  output logic [7:0]         err_count,
  output logic               healthy
);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               present_q, present_d;
  logic [7:0]         err_q, err_d;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    timer_d   = timer_q;
    present_d = present_q;
    err_d     = err_q;

    if (ts_valid && ts_start) begin
      timer_d   = '0;
      present_d = 1'b1;
    end else begin
      if (timer_q != '1) timer_d = timer_q + TIMER_W'(1);
      if (timer_d >= limit) present_d = 1'b0;
    end

    // Window clear wins over an error arriving in the same cycle.
    if (win_clear) err_d = '0;
    else if (ts_err && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q   <= '0;
      present_q <= 1'b0;
      err_q     <= '0;
    end else begin
      timer_q   <= timer_d;
      present_q <= present_d;
      err_q     <= err_d;
    end
  end

  assign present   = present_q;
  assign err_count = err_q;
  assign healthy   = present_q && (int'(err_q) < ERR_THRESH);

endmodule

// File: rtl/qos_channel_selector.sv
// QoS channel selector: picks one of four TS inputs by manual choice or health
// priority, switching only on packet starts. Post-switch guard: QOS_SWITCH_HOLDOFF_EN.
module qos_channel_selector
  import qos_pkg::*;
#(
  parameter int ERR_THRESH  = 8,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fallback_enable,
  input  logic                    manual_enable,
  input  logic [1:0]              manual_channel,
  input  logic [7:0]              channel_priority,
  input  logic [TIMER_W-1:0]      reset_timer,
  input  logic                    valid_config,
  qos_channel_selector_if.slave   ts_if,
  output logic [1:0]              active_channel,
  output logic [NUM_CH-1:0]       signal_present,
  output logic [7:0]              error_count_ch0,
  output logic [7:0]              error_count_ch1,
  output logic [7:0]              error_count_ch2,
  output logic [7:0]              error_count_ch3
);

  qos_cfg_t           cfg_q, cfg_d;
  logic [TIMER_W-1:0] limit;
  logic [TIMER_W-1:0] win_q, win_d;
  logic               win_clear;

  logic [NUM_CH-1:0]  present, healthy;
  logic [7:0]         err_cnt [NUM_CH];

  sel_state_e         state_q, state_d;
  logic [1:0]         active_q, active_d;
  logic [1:0]         target;
  logic               target_start;
  logic               switch_now;

  logic               out_valid_q, out_valid_d;
  logic               out_start_q, out_start_d;
  logic [7:0]         out_data_q, out_data_d;

  // Shadow configuration and the shared error window.
  always_comb begin
    cfg_d = cfg_q;
    if (valid_config) begin
      cfg_d = '{fallback_enable:  fallback_enable,
                manual_enable:    manual_enable,
                manual_channel:   manual_channel,
                channel_priority: channel_priority,
                reset_timer:      reset_timer};
    end
  end

  assign limit     = eff_limit(cfg_q.reset_timer);
  assign win_clear = valid_config || (win_q >= limit - TIMER_W'(1));
  assign win_d     = win_clear ? '0 : win_q + TIMER_W'(1);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_mon
    qos_chan_monitor #(.ERR_THRESH(ERR_THRESH)) u_mon (
      .clk       (clk),
      .rst       (rst),
      .ts_valid  (ts_if.ts_valid[n]),
      .ts_start  (ts_if.ts_start[n]),
      .ts_err    (ts_if.ts_err[n]),
      .win_clear (win_clear),
      .limit     (limit),
      .present   (present[n]),
      .err_count (err_cnt[n]),
      .healthy   (healthy[n])
    );
  end

  // Scan lowest priority first so the highest-priority healthy entry wins.
  always_comb begin
    target = active_q;
    if (cfg_q.manual_enable) begin
      target = cfg_q.manual_channel;
    end else if (cfg_q.fallback_enable) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (healthy[cfg_q.channel_priority[2*i +: 2]]) target = cfg_q.channel_priority[2*i +: 2];
      end
    end
  end

  assign target_start = ts_if.ts_valid[target] && ts_if.ts_start[target];

`ifdef QOS_SWITCH_HOLDOFF_EN
  localparam int GUARD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  logic [GUARD_W-1:0] guard_q, guard_d;
  logic               guard_done;
  logic               manual_override;

  assign guard_done      = int'(guard_q) >= HOLD_CYCLES - 1;
  assign manual_override = cfg_q.manual_enable && (cfg_q.manual_channel != active_q);
`else
  logic unused_hold_cycles;
  assign unused_hold_cycles = (HOLD_CYCLES != 0);
`endif

  // FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_LOCK;
    else     state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    if (valid_config) begin
      state_d = ST_LOCK;
    end else begin
      case (state_q)
        ST_LOCK: if (target != active_q) state_d = ST_PEND;
        ST_PEND: begin
          if (target == active_q) state_d = ST_LOCK;
`ifdef QOS_SWITCH_HOLDOFF_EN
          else if (target_start)  state_d = ST_HOLD;
`else
          else if (target_start)  state_d = ST_LOCK;
`endif
        end
`ifdef QOS_SWITCH_HOLDOFF_EN
        ST_HOLD: begin
          if (manual_override) state_d = ST_PEND;
          else if (guard_done) state_d = ST_LOCK;
        end
`endif
        default: state_d = ST_LOCK;
      endcase
    end
  end

  // FSM outputs: the switch cycle already routes the new channel's start byte.
  always_comb begin
    switch_now  = (state_q == ST_PEND) && !valid_config && (target != active_q) && target_start;
    active_d    = switch_now ? target : active_q;
    out_valid_d = ts_if.ts_valid[active_d];
    out_start_d = ts_if.ts_start[active_d];
    out_data_d  = ts_if.ts_data[8*active_d +: 8];
`ifdef QOS_SWITCH_HOLDOFF_EN
    guard_d = '0;
    if ((state_q == ST_HOLD) && (state_d == ST_HOLD)) guard_d = guard_q + GUARD_W'(1);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q       <= '0;
      win_q       <= '0;
      active_q    <= '0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_data_q  <= '0;
`ifdef QOS_SWITCH_HOLDOFF_EN
      guard_q     <= '0;
`endif
    end else begin
      cfg_q       <= cfg_d;
      win_q       <= win_d;
      active_q    <= active_d;
      out_valid_q <= out_valid_d;
      out_start_q <= out_start_d;
      out_data_q  <= out_data_d;
`ifdef QOS_SWITCH_HOLDOFF_EN
      guard_q     <= valid_config ? '0 : guard_d;
`endif
    end
  end

  assign ts_if.out_valid = out_valid_q;
  assign ts_if.out_start = out_start_q;
  assign ts_if.out_data  = out_data_q;
  assign active_channel  = active_q;
  assign signal_present  = present;
  assign error_count_ch0 = err_cnt[0];
  assign error_count_ch1 = err_cnt[1];
  assign error_count_ch2 = err_cnt[2];
  assign error_count_ch3 = err_cnt[3];

endmodule

// File: tb/tb_qos_channel_selector.sv
// Self-checking bench for qos_channel_selector: directed scenarios plus random
// traffic, checked by a scoreboard fed from a timestamp-based reference model.
module tb_qos_channel_selector;

  localparam int ERR_TH = 8;
  localparam int HOLD   = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_fb = 1'b0, cfg_man = 1'b0, vc = 1'b0;
  logic [1:0]  cfg_mch = '0;
  logic [7:0]  cfg_prio = '0;
  logic [19:0] cfg_rt = '0;
  logic [1:0]  active_channel;
  logic [3:0]  signal_present;
  logic [7:0]  ec0, ec1, ec2, ec3;

  always #5 clk = ~clk;

  qos_channel_selector_if bif ();

  qos_channel_selector #(.ERR_THRESH(ERR_TH), .HOLD_CYCLES(HOLD)) dut (
    .clk              (clk),
    .rst              (rst),
    .fallback_enable  (cfg_fb),
    .manual_enable    (cfg_man),
    .manual_channel   (cfg_mch),
    .channel_priority (cfg_prio),
    .reset_timer      (cfg_rt),
    .valid_config     (vc),
    .ts_if            (bif.slave),
    .active_channel   (active_channel),
    .signal_present   (signal_present),
    .error_count_ch0  (ec0),
    .error_count_ch1  (ec1),
    .error_count_ch2  (ec2),
    .error_count_ch3  (ec3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_LOCK, M_PEND, M_HOLD} mode_e;
  typedef struct { bit fb; bit man; int mch; bit [7:0] prio; int lim; } mcfg_t;

  mcfg_t m_cfg;
  bit    m_pres [4];
  int    m_last [4];
  int    m_err  [4];
  int    m_base, m_cyc, m_act, m_hold;
  mode_e m_mode;

  logic [8:0]  exp_q [$];   // {start, data}
  logic [37:0] st_q  [$];   // {active, present, err3..err0}

  task automatic model_reset();
    m_cfg = '{fb: 1'b0, man: 1'b0, mch: 0, prio: 8'h00, lim: 1048575};
    for (int n = 0; n < 4; n++) begin m_pres[n] = 0; m_last[n] = 0; m_err[n] = 0; end
    m_base = 0; m_cyc = 0; m_act = 0; m_hold = 0; m_mode = M_LOCK;
  endtask

  task automatic model_step(input bit cfg_now, input bit [3:0] v, input bit [3:0] s,
                            input bit [3:0] e, input logic [31:0] dp);
    int k, tgt, sel, c;
    bit wrap;
    bit hl [4];
    logic [37:0] st;
    k = m_cyc + 1;
    for (int n = 0; n < 4; n++) hl[n] = m_pres[n] && (m_err[n] < ERR_TH);
    tgt = m_act;
    if (m_cfg.man) tgt = m_cfg.mch;
    else if (m_cfg.fb) begin
      for (int i = 0; i < 4; i++) begin
        c = (m_cfg.prio >> (2*i)) & 3;
        if (hl[c]) begin tgt = c; break; end
      end
    end
    sel = m_act;
    if (cfg_now) m_mode = M_LOCK;
    else begin
      case (m_mode)
        M_LOCK: if (tgt != m_act) m_mode = M_PEND;
        M_PEND: begin
          if (tgt == m_act) m_mode = M_LOCK;
          else if (v[tgt] && s[tgt]) begin
            sel = tgt; m_act = tgt;
`ifdef QOS_SWITCH_HOLDOFF_EN
            m_mode = M_HOLD; m_hold = HOLD;
`else
            m_mode = M_LOCK;
`endif
          end
        end
        M_HOLD: begin
          if (m_cfg.man && m_cfg.mch != m_act) m_mode = M_PEND;
          else if (m_hold <= 1) m_mode = M_LOCK;
          else m_hold--;
        end
        default: m_mode = M_LOCK;
      endcase
    end
    if (v[sel]) exp_q.push_back({s[sel], dp[8*sel +: 8]});
    wrap = ((k - 1 - m_base) % m_cfg.lim) == (m_cfg.lim - 1);
    for (int n = 0; n < 4; n++) begin
      if (v[n] && s[n]) begin m_pres[n] = 1; m_last[n] = k; end
      else if (m_pres[n] && (k - m_last[n]) >= m_cfg.lim) m_pres[n] = 0;
      if (cfg_now || wrap) m_err[n] = 0;
      else if (e[n] && m_err[n] < 255) m_err[n]++;
    end
    if (cfg_now) begin
      m_cfg = '{fb: cfg_fb, man: cfg_man, mch: int'(cfg_mch), prio: cfg_prio,
                lim: (cfg_rt == 0) ? 1048575 : int'(cfg_rt)};
      m_base = k;
    end
    m_cyc = k;
    st = {2'(m_act), 1'(m_pres[3]), 1'(m_pres[2]), 1'(m_pres[1]), 1'(m_pres[0]),
          8'(m_err[3]), 8'(m_err[2]), 8'(m_err[1]), 8'(m_err[0])};
    st_q.push_back(st);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (st_q.size() > 0)
          check("status", {active_channel, signal_present, ec3, ec2, ec1, ec0}, st_q.pop_front());
        if (bif.out_valid) begin
          if (exp_q.size() == 0) check("stream_extra", bif.out_valid, 1'b0);
          else check("stream", {bif.out_start, bif.out_data}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  bit [3:0] en = '0, err_req = '0;
  bit       rnd_valid = 0, rnd_err = 0;
  int       period [4] = '{16, 16, 16, 16};
  int       ph     [4] = '{0, 0, 0, 0};

  task automatic step();
    bit [3:0] v, s, e;
    logic [31:0] dp;
    for (int n = 0; n < 4; n++) begin
      v[n] = en[n] && (!rnd_valid || ($urandom_range(0, 3) != 0));
      s[n] = v[n] && (ph[n] == 0);
      if (v[n]) ph[n] = (ph[n] + 1) % period[n];
      dp[8*n +: 8] = s[n] ? 8'h47 : 8'($urandom_range(0, 255));
      e[n] = err_req[n] || (rnd_err && ($urandom_range(0, 39) == 0));
    end
    bif.ts_valid = v; bif.ts_start = s; bif.ts_err = e; bif.ts_data = dp;
    model_step(vc, v, s, e, dp);
    @(posedge clk);
    @(negedge clk);
    vc = 1'b0;
    err_req = '0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_cfg(input bit fb, input bit man, input bit [1:0] mch,
                           input bit [7:0] prio, input bit [19:0] rt);
    cfg_fb = fb; cfg_man = man; cfg_mch = mch; cfg_prio = prio; cfg_rt = rt;
    vc = 1'b1;
    step();
  endtask

  task automatic wait_active(input bit [1:0] ch, input int budget, input string name);
    int i = 0;
    while (active_channel != ch && i < budget) begin step(); i++; end
    check(name, active_channel, ch);
  endtask

  initial begin
    bif.ts_valid = '0; bif.ts_start = '0; bif.ts_err = '0; bif.ts_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_active", active_channel, 2'd0);
    check("rst_present", signal_present, 4'd0);
    check("rst_errs", {ec3, ec2, ec1, ec0}, 32'd0);
    check("rst_out", {bif.out_valid, bif.out_start, bif.out_data}, 10'd0);
    rst = 1'b0;

    // Presence: ch0 starts every 50 cycles, ch1 silent, then ch0 stops.
    apply_cfg(0, 0, 2'd0, 8'h00, 20'd100);
    period[0] = 50; ph[0] = 0; en = 4'b0001;
    steps(251);
    check("present_steady", signal_present, 4'b0001);
    en = 4'b0000;
    steps(99);
    check("present_99", signal_present[0], 1'b1);
    step();
    check("present_timeout", signal_present[0], 1'b0);

    // Window wrap coinciding with an error on ch2.
    apply_cfg(0, 0, 2'd0, 8'h00, 20'd20);
    for (int i = 0; i < 19; i++) begin err_req = 4'b0100; step(); end
    check("err_ch2_before_wrap", ec2, 8'd19);
    err_req = 4'b0100; step();
    check("err_ch2_wrap_clear", ec2, 8'd0);

    // Error counter saturation on ch3.
    apply_cfg(0, 0, 2'd0, 8'h00, 20'd0);
    for (int i = 0; i < 300; i++) begin err_req = 4'b1000; step(); end
    check("err_ch3_saturate", ec3, 8'd255);

    // Fallback: ch0 goes bad, switch to ch1 on its packet start.
    period = '{16, 16, 16, 16}; ph = '{0, 5, 10, 3}; en = 4'b0111;
    apply_cfg(1, 0, 2'd0, 8'b11_10_01_00, 20'd4000);
    steps(40);
    check("lock_ch0", active_channel, 2'd0);
    for (int i = 0; i < 8; i++) begin err_req = 4'b0001; step(); end
    wait_active(2'd1, 100, "fallback_to_ch1");
    check("switch_start_byte", {bif.out_start, bif.out_data}, {1'b1, 8'h47});

    // ch1 fails 200 cycles after the switch; guard delays the next switch.
    steps(200);
    for (int i = 0; i < 8; i++) begin err_req = 4'b0010; step(); end
    steps(700);
`ifdef QOS_SWITCH_HOLDOFF_EN
    check("guard_holds_ch1", active_channel, 2'd1);
`else
    check("no_guard_ch2", active_channel, 2'd2);
`endif
    wait_active(2'd2, 400, "fallback_to_ch2");

    // Manual override shortly after a switch.
    en[3] = 1'b1;
    apply_cfg(1, 1, 2'd3, 8'b11_10_01_00, 20'd4000);
    wait_active(2'd3, 60, "manual_ch3");

    // Park in PEND (ch1 present but silent), then assert reset asynchronously.
    en = 4'b1000;
    apply_cfg(1, 0, 2'd0, 8'b00_00_00_01, 20'd1000);
    steps(10);
    check("pend_no_switch", active_channel, 2'd3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_active", active_channel, 2'd0);
    check("async_rst_present", signal_present, 4'd0);
    check("async_rst_errs", {ec3, ec2, ec1, ec0}, 32'd0);
    check("async_rst_out", {bif.out_valid, bif.out_start, bif.out_data}, 10'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    en = 4'b0011;
    steps(20);
    check("post_rst_active", active_channel, 2'd0);

    // Random traffic, errors and reconfiguration against the model.
    rnd_valid = 1; rnd_err = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) begin
        en = 4'($urandom_range(0, 15));
        for (int n = 0; n < 4; n++) begin
          period[n] = $urandom_range(4, 40);
          ph[n] = ph[n] % period[n];
        end
      end
      if ($urandom_range(0, 199) == 0)
        apply_cfg(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                  20'($urandom_range(16, 400)));
      else
        step();
    end

    bif.ts_valid = '0;
    repeat (2) @(negedge clk);
    check("stream_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qos_channel_selector.md
QOS_CHANNEL_SELECTOR -- requirements
Module: qos_channel_selector

Interface
REQ-001 Parameter ERR_THRESH, default 8, error count per window at or above which a channel is unhealthy.
REQ-002 Parameter HOLD_CYCLES, default 1024, post-switch guard length in clk cycles.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 fallback_enable, manual_enable  input  1 each  mode controls from the register block.
REQ-006 manual_channel  input  2  forced channel when manual_enable=1.
REQ-007 channel_priority  input  8  priority list; [1:0] highest, [7:6] lowest.
REQ-008 reset_timer  input  20  presence timeout and error-window length, cycles; 0 means 1,048,575.
REQ-009 valid_config  input  1  one-cycle strobe: new config applied.
REQ-010 ts_valid, ts_start, ts_err  input  4 each  per-channel byte valid, packet-start (0x47 byte) and error pulse.
REQ-011 ts_data  input  32  packed bytes, channel n at [8n+7:8n].
REQ-012 out_valid, out_start  output  1 each; out_data  output  8  selected TS byte stream.
REQ-013 active_channel  output  2; signal_present  output  4; error_count_ch0..3  output  8 each  status to the register block.

Function
REQ-014 Config inputs are captured into shadow registers on valid_config=1; all decisions use the shadow copy.
REQ-015 Per-channel presence timer: cleared and signal_present[n] set to 1 on ts_valid[n]&ts_start[n]; otherwise increments, saturating; signal_present[n] cleared when timer reaches shadow reset_timer.
REQ-016 Global window counter counts 0..reset_timer-1, then wraps; on wrap all error counters clear to 0.
REQ-017 error_count_chn increments on ts_err[n], saturating at 255; wrap clear takes priority over a same-cycle increment.
REQ-018 healthy[n] = signal_present[n] & (error_count_chn < ERR_THRESH).
REQ-019 Target: manual_enable=1 -> manual_channel; else fallback_enable=1 -> first healthy entry of channel_priority; none healthy, or both modes off -> active_channel (no change).
REQ-020 FSM states LOCK, PEND, HOLD; reset state LOCK.
REQ-021 LOCK: target != active_channel -> PEND.
REQ-022 PEND: on ts_valid[target]&ts_start[target], active_channel <= target, -> HOLD; if target returns to active_channel -> LOCK with no switch.
REQ-023 HOLD: guard counter runs HOLD_CYCLES cycles, then -> LOCK; target changes ignored, except manual_enable=1 with manual_channel != active_channel -> PEND immediately.
REQ-024 Switch always lands on a packet start; no partial packet on the output.
REQ-025 Output: out_* = registered ts_*[active_channel] (out_valid from ts_valid), latency 1 cycle; the switching start byte is the first byte emitted from the new channel.
REQ-026 Duplicate priority entries are legal; the first healthy match wins.

Reset
REQ-027 On rst: active_channel=0, signal_present=0, error counters=0, out_valid=out_start=0, out_data=0, all timers 0, FSM=LOCK, shadow config=0.
REQ-028 valid_config additionally clears error counters, window counter and guard counter and forces FSM to LOCK; presence state is retained.

Configuration
REQ-029 Macro QOS_SWITCH_HOLDOFF_EN: defined -> HOLD state and guard counter present per REQ-023; undefined -> PEND transitions directly to LOCK and the HOLD_CYCLES parameter has no effect.

Structure
REQ-030 Shared package qos_pkg holds the FSM state enum, the channel-count constant (4) and the reset_timer-zero substitute constant.
REQ-031 One sub-module qos_chan_monitor, instantiated 4x, holds the presence timer and error counter of a single channel.

Verification
REQ-032 reset_timer=100, ch0 start every 50 cycles, ch1 silent -> signal_present=0001 steady; ch0 stops -> bit 0 clears 100 cycles after its last start.
REQ-033 fallback=1, priority=8'b11_10_01_00, ch0 receives 8 ts_err in a window -> PEND, switch to ch1 on ch1's next start; out_start=1 one cycle later with out_data=0x47.
REQ-034 Window wrap with simultaneous ts_err on ch2 -> error_count_ch2=0 next cycle.
REQ-035 With QOS_SWITCH_HOLDOFF_EN, HOLD_CYCLES=1024: ch1 fails 200 cycles after a switch -> no PEND until the guard expires; manual_enable=1, manual_channel=3 during HOLD -> PEND immediately.
REQ-036 ts_err on ch3 pulsed 300 times -> error_count_ch3 saturates at 255.
REQ-037 rst asserted while in PEND -> all outputs at reset values asynchronously; after release, active_channel=0, FSM=LOCK.
